// File: rtl/adc_spi_responder.sv
// Behavioural ADC128S022-style SPI responder: 16-bit frames, pipelined 3-bit channel addressing.
// Optional build macro ADC_RESP_DITHER_EN adds LFSR dither on the two LSBs of each snapshot.
module adc_spi_responder #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [2:0]  ADDR_RESET     = 3'd0,
    parameter logic [15:0] FRAME_CNT_INIT = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_sclk,
    input  logic        adc_cs_n,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [95:0] ch_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  cur_addr,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_END} state_t;

    // Index SYNC_STAGES-1 is the synchronized level, index SYNC_STAGES the edge-detect delay.
    logic [SYNC_STAGES:0] r_sclk_sync;
    logic [SYNC_STAGES:0] r_cs_sync;
    logic [SYNC_STAGES:0] r_din_sync;

    logic        r_sclk_rise;
    logic        r_sclk_fall;
    logic        r_cs_fall;
    logic        w_cs_lvl;
    logic        w_din_lvl;

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [14:0] r_shift;
    logic [12:0] r_addr_sr;
    logic        r_dout;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [2:0]  r_cur_addr;
    logic [15:0] r_frame_cnt;

    logic [11:0] w_ch [8];
    logic [1:0]  w_dither;
    logic [15:0] w_snap;
    logic        w_frame_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_fall   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], adc_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-1:0], adc_cs_n};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-1:0], adc_din};
            r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
            r_sclk_fall <= ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
            r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_sync[SYNC_STAGES];
        end
    end

    // Delayed levels line up in time with the registered edge strobes.
    assign w_cs_lvl  = r_cs_sync[SYNC_STAGES];
    assign w_din_lvl = r_din_sync[SYNC_STAGES];

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign w_ch[gi] = ch_data[12*gi +: 12];
    end

`ifdef ADC_RESP_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_frame_end) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_dither = r_lfsr[1:0];
`else
    assign w_dither = 2'b00;
`endif

    assign w_snap      = {4'b0000, w_ch[r_cur_addr] ^ {10'd0, w_dither}};
    assign w_frame_end = (r_state == ST_SHIFT) && !w_cs_lvl && r_sclk_rise && (r_bit_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 15'd0;
            r_addr_sr    <= 13'd0;
            r_dout       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cur_addr   <= ADDR_RESET;
            r_frame_cnt  <= FRAME_CNT_INIT;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dout <= 1'b0;
                    if (r_cs_fall) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift   <= w_snap[14:0];
                    r_dout    <= w_snap[15];
                    r_bit_cnt <= 4'd0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_cs_lvl) begin
                        r_frame_err <= 1'b1;
                        r_dout      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_sclk_rise) begin
                        r_addr_sr <= {r_addr_sr[11:0], w_din_lvl};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_frame_end) begin
                            // r_addr_sr holds frame bits 13:1 here, so 12:10 are DIN bits 13:11.
                            r_cur_addr   <= r_addr_sr[12:10];
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                            r_state      <= ST_END;
                        end
                    end else if (r_sclk_fall && (r_bit_cnt != 4'd0)) begin
                        // The leading fall keeps bit 15 on the line for the first rise.
                        r_dout  <= r_shift[14];
                        r_shift <= {r_shift[13:0], 1'b0};
                    end
                end
                ST_END: begin
                    if (w_cs_lvl) begin
                        r_dout  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_sclk_fall) begin
                        r_shift   <= w_snap[14:0];
                        r_dout    <= w_snap[15];
                        r_bit_cnt <= 4'd0;
                        r_state   <= ST_SHIFT;
                    end
                end
                default: begin
                    r_dout  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_dout   = r_dout;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign cur_addr   = r_cur_addr;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Behavioural SPI responder for the ADC128S022-style 8-channel, 12-bit converter that the ADC controller polls. It samples the controller's SCLK/CS_N/DIN on the system clock, decodes the 3-bit channel address, and shifts out a 12-bit channel value on DOUT. It is used in place of the physical ADC in simulation and hardware-in-loop builds, so the two cascaded PI loops can run against programmable CH0..CH7 values.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on SCLK/CS_N/DIN; legal range 2..3.
- ADDR_RESET, 3'd0: channel served in the first frame after reset.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset (sampled on rising clk).
- adc_sclk  in  1  SPI clock from the controller; idles high.
- adc_cs_n  in  1  frame select from the controller; active low.
- adc_din  in  1  control word from the controller, MSB first.
- adc_dout  out  1  conversion data to the controller, MSB first.
- ch_data  in  96  channel values; channel k is ch_data[12k+11:12k].
- frame_done  out  1  one-clk pulse when a complete 16-bit frame ends.
- frame_err  out  1  one-clk pulse when CS_N rises mid-frame.
- cur_addr  out  3  channel served in the next frame.
- frame_cnt  out  16  count of completed frames; wraps at 65535 to 0.

## Operation
- SCLK, CS_N and DIN each pass through SYNC_STAGES flops, plus one extra flop for edge detection. Rise and fall events are single-clk strobes.
- FSM states:
  - IDLE: CS_N high; adc_dout = 0.
  - LOAD: one clk after the CS_N fall is detected.
    - Snapshot ch_data[cur_addr] into a 16-bit shift register {4'b0, value}.
    - Clear the bit counter.
    - Drive bit 15 (0).
  - SHIFT: active transfer.
    - On each SCLK rise: shift adc_din into the address shift register and increment the bit counter (0..15).
    - On each SCLK fall: shift out the next bit.
  - END: entered on the 16th SCLK rise.
    - Update cur_addr to DIN bits 13:11 of the frame, which are the 3rd..5th bits received.
    - Pulse frame_done and increment frame_cnt.
    - If CS_N is still low, the next SCLK fall starts the next frame. This is continuous mode: re-snapshot using the new cur_addr, then go to SHIFT.
    - If CS_N is high, go to IDLE.
- CS_N rise in SHIFT before 16 rises: abort, pulse frame_err, cur_addr and frame_cnt unchanged, go to IDLE.
- Pipelined addressing: data in frame N is the channel addressed in frame N-1. The first frame after reset serves ADDR_RESET.
- Changes to ch_data during a frame have no effect until the next snapshot.
- SCLK edges while CS_N is high are ignored.
- Reset values:
  - adc_dout = 0, frame_done = 0, frame_err = 0.
  - cur_addr = ADDR_RESET, frame_cnt = 0.
  - FSM = IDLE.
- Reset asserted mid-frame abandons the frame. frame_err is not pulsed.

## Timing
- Pin-to-strobe latency is SYNC_STAGES+1 clk.
- adc_dout updates 1 clk after the fall strobe, i.e. ≤ SYNC_STAGES+2 clk after the pin edge.
- SCLK high and low phases must each be ≥ SYNC_STAGES+4 clk, so DOUT settles before the controller samples on the rising edge.
- CS_N fall to first SCLK fall must be ≥ SYNC_STAGES+3 clk.
- frame_done and frame_err last exactly 1 clk. They are never asserted in the same clk.
- cur_addr updates in the same clk as frame_done.

## Configuration
- ADC_RESP_DITHER_EN:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per frame.
  - The LFSR's two LSBs are XORed into the two LSBs of the snapshot value before shifting out.
  - Defined or not, frame timing and all status outputs are identical.
- Not defined: the LFSR is absent and the value is passed through exactly.

## Test plan
- Reset, then one frame with DIN addr=3 and ch_data[0]=12'hABC. Required:
  - DOUT stream = 0000_1010_1011_1100.
  - cur_addr=3, frame_done one pulse, frame_cnt=1.
- Next frame with ch_data[3]=12'h5A5. Required: DOUT = 0000_0101_1010_0101, proving pipelined addressing.
- CS_N held low for 3 back-to-back frames addressing 1, 2, 7. Required:
  - Three frame_done pulses, frame_cnt=3.
  - Served channels are 0, 1, 2; cur_addr=7.
- CS_N raised after 9 SCLK rises. Required: frame_err one pulse, cur_addr and frame_cnt unchanged, adc_dout=0 in IDLE.
- rst driven low after 6 bits, then released. Required:
  - All outputs return to reset values, no frame_err.
  - Next full frame serves ADDR_RESET.
- Preload frame_cnt path to 65535 via 65535 frames (accelerated bench), then one more frame. Required: frame_cnt=0.
  - With ADC_RESP_DITHER_EN defined, ch_data=12'h800 yields DOUT values differing from 12'h800 only in bits 1:0.
